// File: rtl/alu_muldiv.sv
// alu_muldiv: registered RISC-V execute-stage ALU with an optional radix-2
// multiply/divide engine. Define ALU_MULDIV_EN to build the M-extension
// engine; without it every Operation[4]=1 code returns 0 in one cycle.
module alu_muldiv #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     busy
);
   localparam int SHW = $clog2(DATA_WIDTH);

   logic [4:0]            opc;
   logic [SHW-1:0]        shamt;
   logic [DATA_WIDTH-1:0] base_res;

   assign opc   = Operation[4:0];
   assign shamt = SrcB[SHW-1:0];

   // Single-cycle base operations; unlisted codes (including the M group) give 0
   always_comb begin
      base_res = '0;
      case (opc)
         5'b00000: base_res = SrcA & SrcB;
         5'b00001: base_res = SrcA | SrcB;
         5'b00101: base_res = SrcA + SrcB;
         5'b00011: base_res = SrcA - SrcB;
         5'b00100: base_res = SrcA ^ SrcB;
         5'b00010: base_res = $unsigned($signed(SrcA) >>> shamt);
         5'b01100: base_res = SrcA >> shamt;
         5'b01101: base_res = SrcA << shamt;
         5'b01000: base_res[0] = (SrcA == SrcB);
         5'b01001: base_res[0] = (SrcA != SrcB);
         5'b01010: base_res[0] = ($signed(SrcA) < $signed(SrcB));
         5'b01011: base_res[0] = ($signed(SrcA) >= $signed(SrcB));
         5'b01110: base_res[0] = ($signed(SrcA) < $signed(SrcB));
         5'b00110: base_res[0] = (SrcA < SrcB);
         default:  base_res = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] hi;    // product high word / partial remainder
   logic [DATA_WIDTH-1:0] lo;    // multiplier, then product low / quotient
   logic [DATA_WIDTH-1:0] mop;   // multiplicand or divisor magnitude
   logic [2:0]            op_q;
   logic                  sa;
   logic                  sb;
   logic                  dz;

   logic                  m_code;
   logic                  sgn;
   logic                  a_neg;
   logic                  b_neg;
   logic [DATA_WIDTH-1:0] mag_a;
   logic [DATA_WIDTH-1:0] mag_b;
   logic [DATA_WIDTH:0]   mul_sum;
   logic [DATA_WIDTH:0]   div_sh;
   logic [DATA_WIDTH:0]   div_diff;
   logic [DATA_WIDTH-1:0] fix_res;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Operand decode and per-iteration datapath for the iterative engine
   always_comb begin
      m_code   = (opc[4:3] == 2'b10) && (opc[2:0] != 3'b011);
      sgn      = (opc[2:0] == 3'b001) || (opc[2] && !opc[0]);
      a_neg    = sgn && SrcA[DATA_WIDTH-1];
      b_neg    = sgn && SrcB[DATA_WIDTH-1];
      mag_a    = a_neg ? -SrcA : SrcA;
      mag_b    = b_neg ? -SrcB : SrcB;
      mul_sum  = {1'b0, hi};
      if (lo[0]) mul_sum = {1'b0, hi} + {1'b0, mop};
      div_sh   = {hi, lo[DATA_WIDTH-1]};
      div_diff = div_sh - {1'b0, mop};
   end

   // Sign correction; high word of -{hi,lo} is ~hi plus the carry out of ~lo+1
   always_comb begin
      fix_res = '0;
      case (op_q)
         3'b000: fix_res = lo;
         3'b001: fix_res = (sa ^ sb) ? (~hi + DATA_WIDTH'(lo == '0)) : hi;
         3'b010: fix_res = hi;
         3'b100: fix_res = dz ? '1 : ((sa ^ sb) ? -lo : lo);
         3'b101: fix_res = dz ? '1 : lo;
         3'b110: fix_res = sa ? -hi : hi;
         3'b111: fix_res = hi;
         default: fix_res = '0;
      endcase
   end

   // Control FSM and engine registers: IDLE accepts, CALC iterates, FIX emits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         ALUResult <= '0;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         mop       <= '0;
         op_q      <= '0;
         sa        <= 1'b0;
         sb        <= 1'b0;
         dz        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (in_valid) begin
                  if (m_code) begin
                     state <= CALC;
                     cnt   <= '0;
                     hi    <= '0;
                     lo    <= opc[2] ? mag_a : mag_b;
                     mop   <= opc[2] ? mag_b : mag_a;
                     op_q  <= opc[2:0];
                     sa    <= a_neg;
                     sb    <= b_neg;
                     dz    <= (SrcB == '0);
                  end else begin
                     out_valid <= 1'b1;
                     ALUResult <= base_res;
                  end
               end
            end
            CALC: begin
               if (op_q[2]) begin
                  if (!div_diff[DATA_WIDTH]) begin
                     hi <= div_diff[DATA_WIDTH-1:0];
                     lo <= {lo[DATA_WIDTH-2:0], 1'b1};
                  end else begin
                     hi <= div_sh[DATA_WIDTH-1:0];
                     lo <= {lo[DATA_WIDTH-2:0], 1'b0};
                  end
               end else begin
                  hi <= mul_sum[DATA_WIDTH:1];
                  lo <= {mul_sum[0], lo[DATA_WIDTH-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == DATA_WIDTH'(DATA_WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               ALUResult <= fix_res;
               out_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign in_ready = 1'b1;
   assign busy     = 1'b0;

   // Every operation, including M-group codes (which decode to 0), completes in one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         ALUResult <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) ALUResult <= base_res;
      end
   end
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: vector table, hand sequences and a
// randomized run against a plain-arithmetic reference model.
module tb_alu_muldiv;
   localparam int W  = 32;
   localparam int ML = W + 2;
`ifdef ALU_MULDIV_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  SrcA = '0;
   logic [W-1:0]  SrcB = '0;
   logic [4:0]    Operation = '0;
   logic          out_valid;
   logic [W-1:0]  ALUResult;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit busy_seen = 1'b0;

   alu_muldiv #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
      .out_valid(out_valid), .ALUResult(ALUResult), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (busy === 1'b1) busy_seen = 1'b1;

   typedef struct {
      logic [4:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit is_mop(input logic [4:0] op);
      return (op[4:3] == 2'b10) && (op[2:0] != 3'b011);
   endfunction

   function automatic int lat_of(input logic [4:0] op);
      return (EN && is_mop(op)) ? ML : 1;
   endfunction

   // Reference model from the operation definitions using 64-bit arithmetic
   function automatic logic [W-1:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int          ia, ib;
      int unsigned sh;
      longint      sp;
      logic [63:0] up;
      ia = a; ib = b; sh = b % W;
      case (op)
         5'd0:  return a & b;
         5'd1:  return a | b;
         5'd5:  return a + b;
         5'd3:  return a - b;
         5'd4:  return a ^ b;
         5'd2:  return ia >>> sh;
         5'd12: return a >> sh;
         5'd13: return a << sh;
         5'd8:  return (a == b) ? 1 : 0;
         5'd9:  return (a != b) ? 1 : 0;
         5'd10, 5'd14: return (ia < ib) ? 1 : 0;
         5'd11: return (ia >= ib) ? 1 : 0;
         5'd6:  return (a < b) ? 1 : 0;
         default: ;
      endcase
      if (!EN || !is_mop(op)) return '0;
      case (op)
         5'd16: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
         5'd17: begin sp = longint'(ia) * longint'(ib); up = sp; return up[63:32]; end
         5'd18: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         5'd20: begin
            if (b == 0) return '1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         5'd21: return (b == 0) ? '1 : a / b;
         5'd22: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
            return ia % ib;
         end
         5'd23: return (b == 0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   // Issue one op, then check latency, busy profile, result and single pulse
   task automatic run_op(input string name, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
      int k;
      int busy_bad;
      int lat;
      bit got;
      lat = lat_of(op);
      @(negedge clk);
      Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 100) begin @(negedge clk); k++; end
      if (!in_ready) check({name, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      SrcA = $urandom; SrcB = $urandom; Operation = 5'($urandom);
      k = 0; busy_bad = 0; got = 1'b0;
      while (k < lat + 5 && !got) begin
         @(negedge clk); k++;
         if (out_valid) got = 1'b1;
         else if (busy !== (lat > 1)) busy_bad++;
      end
      check({name, "_latency"}, W'(k), W'(lat));
      check({name, "_result"}, ALUResult, exp);
      check({name, "_busy"}, W'(busy_bad), 32'd0);
      @(negedge clk);
      check({name, "_pulse"}, W'(out_valid), 32'd0);
   endtask

   initial begin
      logic [4:0]   rop;
      logic [W-1:0] ra, rb;
      logic [W-1:0] corners[6];
      int pulses, k1, k2, ov;
      logic [W-1:0] r1, r2;

      vecs.push_back('{op: 5'b10000, a: 32'hFFFF_FFFF, b: 32'd2,          exp: 32'hFFFF_FFFE});
      vecs.push_back('{op: 5'b10001, a: 32'hFFFF_FFFE, b: 32'd3,          exp: 32'hFFFF_FFFF});
      vecs.push_back('{op: 5'b10010, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF,  exp: 32'hFFFF_FFFE});
      vecs.push_back('{op: 5'b10001, a: 32'h8000_0000, b: 32'h8000_0000,  exp: 32'h4000_0000});
      vecs.push_back('{op: 5'b10100, a: 32'hFFFF_FFF9, b: 32'd2,          exp: 32'hFFFF_FFFD});
      vecs.push_back('{op: 5'b10110, a: 32'hFFFF_FFF9, b: 32'd2,          exp: 32'hFFFF_FFFF});
      vecs.push_back('{op: 5'b10101, a: 32'd100,       b: 32'd0,          exp: 32'hFFFF_FFFF});
      vecs.push_back('{op: 5'b10111, a: 32'd100,       b: 32'd0,          exp: 32'd100});
      vecs.push_back('{op: 5'b10100, a: 32'hFFFF_FFF9, b: 32'd0,          exp: 32'hFFFF_FFFF});
      vecs.push_back('{op: 5'b10110, a: 32'hFFFF_FFF9, b: 32'd0,          exp: 32'hFFFF_FFF9});
      vecs.push_back('{op: 5'b10100, a: 32'h8000_0000, b: 32'hFFFF_FFFF,  exp: 32'h8000_0000});
      vecs.push_back('{op: 5'b10110, a: 32'h8000_0000, b: 32'hFFFF_FFFF,  exp: 32'd0});
      vecs.push_back('{op: 5'b00011, a: 32'd0,         b: 32'd1,          exp: 32'hFFFF_FFFF});
      vecs.push_back('{op: 5'b01101, a: 32'd1,         b: 32'd33,         exp: 32'd2});
      vecs.push_back('{op: 5'b01100, a: 32'h8000_0000, b: 32'd31,         exp: 32'd1});
      vecs.push_back('{op: 5'b01000, a: 32'd5,         b: 32'd5,          exp: 32'd1});
      vecs.push_back('{op: 5'b01001, a: 32'd5,         b: 32'd5,          exp: 32'd0});
      vecs.push_back('{op: 5'b01010, a: 32'h8000_0000, b: 32'd0,          exp: 32'd1});
      vecs.push_back('{op: 5'b01011, a: 32'hFFFF_FFFF, b: 32'd0,          exp: 32'd0});
      vecs.push_back('{op: 5'b10011, a: 32'd7,         b: 32'd9,          exp: 32'd0});
      vecs.push_back('{op: 5'b11000, a: 32'd7,         b: 32'd9,          exp: 32'd0});
      vecs.push_back('{op: 5'b00111, a: 32'd7,         b: 32'd9,          exp: 32'd0});

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_result", ALUResult, 32'd0);
      check("rst_out_valid", W'(out_valid), 32'd0);
      check("rst_busy", W'(busy), 32'd0);
      check("rst_in_ready", W'(in_ready), 32'd1);
      reset = 1'b0;

      // Back-to-back base ops, one per cycle
      @(negedge clk);
      Operation = 5'b00101; SrcA = 32'd5; SrcB = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      check("b2b_add_valid", W'(out_valid), 32'd1);
      check("b2b_add", ALUResult, 32'd12);
      Operation = 5'b01110; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
      @(negedge clk);
      check("b2b_slt", ALUResult, 32'd1);
      Operation = 5'b00110; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
      @(negedge clk);
      check("b2b_sltu", ALUResult, 32'd0);
      Operation = 5'b00010; SrcA = 32'h8000_0000; SrcB = 32'd4;
      @(negedge clk);
      check("b2b_sra_valid", W'(out_valid), 32'd1);
      check("b2b_sra", ALUResult, 32'hF800_0000);
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b_idle", W'(out_valid), 32'd0);

      // Vector table
      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                (EN || !is_mop(vecs[i].op)) ? vecs[i].exp : 32'd0);
      end

`ifdef ALU_MULDIV_EN
      // ADD held on in_valid during a DIV waits for in_ready
      @(negedge clk);
      Operation = 5'b10100; SrcA = 32'hFFFF_FFF9; SrcB = 32'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      Operation = 5'b00101; SrcA = 32'd3; SrcB = 32'd4;
      pulses = 0; k1 = 0; k2 = 0; r1 = '0; r2 = '0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (out_valid) begin
            pulses++;
            if (pulses == 1) begin k1 = k; r1 = ALUResult; end
            else if (pulses == 2) begin k2 = k; r2 = ALUResult; in_valid = 1'b0; end
         end
      end
      in_valid = 1'b0;
      check("hold_pulses", W'(pulses), 32'd2);
      check("hold_div_lat", W'(k1), W'(ML));
      check("hold_div_res", r1, 32'hFFFF_FFFD);
      check("hold_add_lat", W'(k2), W'(ML + 1));
      check("hold_add_res", r2, 32'd7);
`else
      run_op("nomd_mul", 5'b10000, 32'd3, 32'd4, 32'd0);
`endif

      // Reset during a DIV aborts it
      run_op("pre_rst_add", 5'b00101, 32'd10, 32'd20, 32'd30);
      @(negedge clk);
      Operation = 5'b10100; SrcA = 32'd1000; SrcB = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_result", ALUResult, 32'd0);
      check("abort_out_valid", W'(out_valid), 32'd0);
      check("abort_busy", W'(busy), 32'd0);
      check("abort_in_ready", W'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      ov = 0;
      repeat (40) begin @(negedge clk); if (out_valid) ov++; end
      check("abort_no_valid", W'(ov), 32'd0);
      run_op("post_rst_add", 5'b00101, 32'd1, 32'd1, 32'd2);

      // Randomized ops against the reference model
      corners[0] = 32'd0;          corners[1] = 32'd1;
      corners[2] = 32'hFFFF_FFFF;  corners[3] = 32'h8000_0000;
      corners[4] = 32'h7FFF_FFFF;  corners[5] = 32'd2;
      for (int n = 0; n < 120; n++) begin
         rop = 5'($urandom_range(0, 31));
         ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
         rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
         if ($urandom_range(0, 3) == 0) rb = rb % 40;
         run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, ref_alu(rop, ra, rb));
      end

`ifndef ALU_MULDIV_EN
      check("nomd_busy_never", W'(busy_seen), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
